// File: rtl/io_port_pkg.sv
// io_port_pkg: shared constants for the memory-mapped I/O port block.
// Holds the register index map, STATUS bit positions, bus widths and the
// IO window base address (0xFFFF0000).
package io_port_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 13;
  localparam int unsigned KBD_W  = 8;
  localparam int unsigned BTN_W  = 4;

  localparam logic [31:0] IO_BASE_ADDR = 32'hFFFF_0000;

  // Register index = addr[3:2]
  localparam logic [1:0] IDX_KEYDATA = 2'd0;
  localparam logic [1:0] IDX_STATUS  = 2'd1;
  localparam logic [1:0] IDX_MSCOUNT = 2'd2;
  localparam logic [1:0] IDX_LEDS    = 2'd3;

  // STATUS register layout
  localparam int unsigned ST_NOT_EMPTY = 0;
  localparam int unsigned ST_FULL      = 1;
  localparam int unsigned ST_OVERFLOW  = 2;
  localparam int unsigned ST_COUNT_LSB = 4;
  localparam int unsigned ST_BTN_LSB   = 8;

  // LEDS register: irq enable bit (only present when IO_PORT_IRQ_EN is defined)
  localparam int unsigned LEDS_IRQ_EN_BIT = 31;

  // Clamp a FIFO occupancy value to the 4-bit STATUS count field.
  function automatic logic [3:0] satCount4(input logic [31:0] cnt);
    return (cnt > 32'd15) ? 4'd15 : 4'(cnt);
  endfunction

endpackage

// File: rtl/io_port_ctrl_if.sv
// io_port_ctrl_if: CPU-side memory bus into the IO port block.
//   en       - memEnable[2] from the decoder
//   addr     - 13-bit physical offset
//   memWrite - store strobe, memRead - load strobe
//   wdata    - store data, rdata - combinational load data
// master = CPU/decoder side, slave = io_port_ctrl.
interface io_port_ctrl_if import io_port_pkg::*; ();

  logic              en;
  logic [ADDR_W-1:0] addr;
  logic              memWrite;
  logic              memRead;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;

  modport master (output en, addr, memWrite, memRead, wdata, input rdata);
  modport slave  (input en, addr, memWrite, memRead, wdata, output rdata);

endinterface

// File: rtl/io_kbd_fifo.sv
// io_kbd_fifo: circular scan-code FIFO with head/tail pointers and count.
// Ports:
//   clk, rst        - clock, async active-low reset
//   push, pushData  - write request (ignored when full)
//   pop             - read request (ignored when empty)
//   headData        - current head entry (valid when !empty)
//   full, empty     - combinational occupancy flags
//   count           - number of stored entries
// DEPTH must be a power of two so the pointers wrap naturally.
module io_kbd_fifo #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = 8,
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] pushData,
  input  logic             pop,
  output logic [WIDTH-1:0] headData,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] headPtr;
  logic [PTR_W-1:0] tailPtr;
  logic             doPush;
  logic             doPop;

  assign full     = (count == CNT_W'(DEPTH));
  assign empty    = (count == '0);
  assign doPush   = push && !full;
  assign doPop    = pop && !empty;
  assign headData = mem[headPtr];

  // Storage carries no reset; occupancy is tracked by count alone.
  always_ff @(posedge clk) begin
    if (doPush) mem[tailPtr] <= pushData;
  end

  // Pointers and occupancy
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      headPtr <= '0;
      tailPtr <= '0;
      count   <= '0;
    end else begin
      if (doPush) tailPtr <= tailPtr + PTR_W'(1);
      if (doPop)  headPtr <= headPtr + PTR_W'(1);
      case ({doPush, doPop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/io_port_ctrl.sv
// io_port_ctrl: memory-mapped IO peripheral for window 0xFFFF0000-0xFFFF000C.
// Registers: KEYDATA (0x0, read pops), STATUS (0x4), MS_COUNT (0x8), LEDS (0xC).
// Ports:
//   clk, rst        - clock, async active-low reset
//   bus             - io_port_ctrl_if.slave (en/addr/memWrite/memRead/wdata/rdata)
//   kbd_code/valid  - scan-code push interface (clk domain)
//   btn             - raw asynchronous push-buttons
//   leds            - LED register output
//   irq             - registered interrupt, only with IO_PORT_IRQ_EN defined
// Optional feature macro: IO_PORT_IRQ_EN (adds irq port and LEDS[31] irq enable).
module io_port_ctrl import io_port_pkg::*; #(
  parameter int unsigned CLK_FREQ_HZ = 25000000,
  parameter int unsigned FIFO_DEPTH  = 8,
  parameter int unsigned LED_WIDTH   = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  io_port_ctrl_if.slave        bus,
  input  logic [KBD_W-1:0]     kbd_code,
  input  logic                 kbd_valid,
  input  logic [BTN_W-1:0]     btn,
  output logic [LED_WIDTH-1:0] leds
`ifdef IO_PORT_IRQ_EN
  ,
  output logic                 irq
`endif
);

  localparam int unsigned PRESC_TERM = CLK_FREQ_HZ / 1000 - 1;
  localparam int unsigned PRESC_W    = (PRESC_TERM > 0) ? $clog2(PRESC_TERM + 1) : 1;
  localparam int unsigned FIFO_PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned FIFO_CNT_W = FIFO_PTR_W + 1;

  // Address decode
  logic       accessOk;
  logic [1:0] regIdx;
  logic       rdStrobe;
  logic       wrStrobe;
  logic       unusedAddrBits;

  assign accessOk       = bus.en && (bus.addr[ADDR_W-1:4] == '0);
  assign regIdx         = bus.addr[3:2];
  assign rdStrobe       = accessOk && bus.memRead;
  assign wrStrobe       = accessOk && bus.memWrite;
  assign unusedAddrBits = ^bus.addr[1:0];

  // Keyboard FIFO
  logic [KBD_W-1:0]      fifoHead;
  logic                  fifoFull;
  logic                  fifoEmpty;
  logic [FIFO_CNT_W-1:0] fifoCount;
  logic                  popReq;

  assign popReq = rdStrobe && (regIdx == IDX_KEYDATA);

  io_kbd_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (KBD_W)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (kbd_valid),
    .pushData (kbd_code),
    .pop      (popReq),
    .headData (fifoHead),
    .full     (fifoFull),
    .empty    (fifoEmpty),
    .count    (fifoCount)
  );

  // Sticky overflow: a dropped code in the same cycle as a clear keeps it set.
  logic overflow;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      overflow <= 1'b0;
    end else if (kbd_valid && fifoFull) begin
      overflow <= 1'b1;
    end else if (wrStrobe && (regIdx == IDX_STATUS) && bus.wdata[ST_OVERFLOW]) begin
      overflow <= 1'b0;
    end
  end

  // Millisecond counter; a software load overrides the terminal-cycle increment.
  logic [PRESC_W-1:0] prescaler;
  logic [31:0]        msCount;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prescaler <= '0;
      msCount   <= '0;
    end else if (wrStrobe && (regIdx == IDX_MSCOUNT)) begin
      prescaler <= '0;
      msCount   <= bus.wdata;
    end else if (prescaler == PRESC_W'(PRESC_TERM)) begin
      prescaler <= '0;
      msCount   <= msCount + 32'd1;
    end else begin
      prescaler <= prescaler + PRESC_W'(1);
    end
  end

  // LED register (and irq enable when present)
`ifdef IO_PORT_IRQ_EN
  logic irqEnable;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      leds      <= '0;
`ifdef IO_PORT_IRQ_EN
      irqEnable <= 1'b0;
`endif
    end else if (wrStrobe && (regIdx == IDX_LEDS)) begin
      leds      <= bus.wdata[LED_WIDTH-1:0];
`ifdef IO_PORT_IRQ_EN
      irqEnable <= bus.wdata[LEDS_IRQ_EN_BIT];
`endif
    end
  end

  // Two-flop button synchronizer
  logic [BTN_W-1:0] btnMeta;
  logic [BTN_W-1:0] btnSync;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      btnMeta <= '0;
      btnSync <= '0;
    end else begin
      btnMeta <= btn;
      btnSync <= btnMeta;
    end
  end

`ifdef IO_PORT_IRQ_EN
  // Interrupt, registered from current FIFO/overflow state
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      irq <= 1'b0;
    end else begin
      irq <= irqEnable && (!fifoEmpty || overflow);
    end
  end
`endif

  // STATUS word assembly
  logic [DATA_W-1:0] statusWord;

  always_comb begin
    statusWord                          = '0;
    statusWord[ST_NOT_EMPTY]            = !fifoEmpty;
    statusWord[ST_FULL]                 = fifoFull;
    statusWord[ST_OVERFLOW]             = overflow;
    statusWord[ST_COUNT_LSB +: 4]       = satCount4(32'(fifoCount));
    statusWord[ST_BTN_LSB +: BTN_W]     = btnSync;
  end

  // Combinational read mux; zero unless a valid read is in progress
  always_comb begin
    bus.rdata = '0;
    if (rdStrobe) begin
      case (regIdx)
        IDX_KEYDATA: bus.rdata = fifoEmpty ? '0 : DATA_W'(fifoHead);
        IDX_STATUS:  bus.rdata = statusWord;
        IDX_MSCOUNT: bus.rdata = msCount;
        IDX_LEDS: begin
          bus.rdata = DATA_W'(leds);
`ifdef IO_PORT_IRQ_EN
          bus.rdata[LEDS_IRQ_EN_BIT] = irqEnable;
`endif
        end
      endcase
    end
  end

endmodule

// File: tb/tb_io_port_ctrl.sv
// tb_io_port_ctrl: directed, scoreboard-based bench for io_port_ctrl.
// Scan codes are pushed to a reference queue as they are driven and popped
// when KEYDATA is read back; STATUS expectations derive from the same model.
module tb_io_port_ctrl;
  import io_port_pkg::*;

  localparam int unsigned CLK_FREQ_HZ = 4000;
  localparam int unsigned FIFO_DEPTH  = 8;
  localparam int unsigned LED_WIDTH   = 16;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [7:0]           kbd_code;
  logic                 kbd_valid;
  logic [3:0]           btn;
  logic [LED_WIDTH-1:0] leds;
`ifdef IO_PORT_IRQ_EN
  logic                 irq;
`endif

  io_port_ctrl_if bus ();

  io_port_ctrl #(
    .CLK_FREQ_HZ (CLK_FREQ_HZ),
    .FIFO_DEPTH  (FIFO_DEPTH),
    .LED_WIDTH   (LED_WIDTH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .kbd_code  (kbd_code),
    .kbd_valid (kbd_valid),
    .btn       (btn),
    .leds      (leds)
`ifdef IO_PORT_IRQ_EN
    ,
    .irq       (irq)
`endif
  );

  always #5 clk = ~clk;

  int         testCount = 0;
  int         failCount = 0;
  logic [7:0] sbQ[$];
  logic       ovfModel;
  logic [3:0] btnModel;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    testCount++;
    assert (obs === exp) else begin
      failCount++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] expStatus();
    logic [31:0] s;
    int          n;
    n       = sbQ.size();
    s       = '0;
    s[0]    = (n != 0);
    s[1]    = (n == int'(FIFO_DEPTH));
    s[2]    = ovfModel;
    s[7:4]  = (n > 15) ? 4'd15 : 4'(n);
    s[11:8] = btnModel;
    return s;
  endfunction

  function automatic logic [12:0] addrOf(input logic [31:0] off);
    logic [31:0] full;
    full = IO_BASE_ADDR + off;
    return full[12:0];
  endfunction

  task automatic busIdle();
    bus.en       = 1'b0;
    bus.addr     = '0;
    bus.memRead  = 1'b0;
    bus.memWrite = 1'b0;
    bus.wdata    = '0;
  endtask

  // One-cycle read strobe; data sampled combinationally mid-cycle.
  task automatic rdReg(input logic [31:0] off, output logic [31:0] data);
    bus.en      = 1'b1;
    bus.addr    = addrOf(off);
    bus.memRead = 1'b1;
    #1;
    data = bus.rdata;
    @(posedge clk);
    #1;
    busIdle();
  endtask

  task automatic wrReg(input logic [31:0] off, input logic [31:0] data);
    bus.en       = 1'b1;
    bus.addr     = addrOf(off);
    bus.memWrite = 1'b1;
    bus.wdata    = data;
    @(posedge clk);
    #1;
    busIdle();
  endtask

  function automatic void modelPush(input logic [7:0] code, input bit wasFull);
    if (wasFull) ovfModel = 1'b1;
    else         sbQ.push_back(code);
  endfunction

  task automatic pushKey(input logic [7:0] code);
    kbd_code  = code;
    kbd_valid = 1'b1;
    modelPush(code, sbQ.size() == int'(FIFO_DEPTH));
    @(posedge clk);
    #1;
    kbd_valid = 1'b0;
  endtask

  task automatic readKey(input string tag);
    logic [31:0] d;
    logic [31:0] e;
    rdReg(32'h0, d);
    e = (sbQ.size() != 0) ? 32'(sbQ.pop_front()) : 32'h0;
    check(tag, d, e);
  endtask

  task automatic checkStatus(input string tag);
    logic [31:0] d;
    rdReg(32'h4, d);
    check(tag, d, expStatus());
  endtask

  // Push and KEYDATA read in the same cycle
  task automatic pushAndRead(input logic [7:0] code, input string tag);
    logic [31:0] d;
    logic [31:0] e;
    bit          wasFull;
    wasFull     = (sbQ.size() == int'(FIFO_DEPTH));
    kbd_code    = code;
    kbd_valid   = 1'b1;
    bus.en      = 1'b1;
    bus.addr    = addrOf(32'h0);
    bus.memRead = 1'b1;
    #1;
    d = bus.rdata;
    e = (sbQ.size() != 0) ? 32'(sbQ.pop_front()) : 32'h0;
    modelPush(code, wasFull);
    check(tag, d, e);
    @(posedge clk);
    #1;
    kbd_valid = 1'b0;
    busIdle();
  endtask

  initial begin
    logic [31:0] d;
    rst       = 1'b0;
    kbd_code  = '0;
    kbd_valid = 1'b0;
    btn       = '0;
    ovfModel  = 1'b0;
    btnModel  = '0;
    busIdle();
    repeat (3) @(posedge clk);
    #3 rst = 1'b1;
    @(posedge clk);
    #1;

    // Reset state
    checkStatus("reset_status");
    readKey("reset_keydata");
    check("reset_leds", 32'(leds), 32'h0);

    // Three codes in, then drained in order
    pushKey(8'h1C);
    pushKey(8'h32);
    pushKey(8'h21);
    checkStatus("status_three");
    check("status_three_lit", expStatus(), 32'h31);
    readKey("key_1c");
    readKey("key_32");
    readKey("key_21");
    checkStatus("status_drained");
    readKey("pop_empty");
    checkStatus("status_after_empty_pop");

    // Nine pushes into an 8-deep FIFO: ninth lost, overflow sticky
    for (int i = 0; i < 9; i++) pushKey(8'(8'h40 + i));
    checkStatus("status_overflow");
    wrReg(32'h4, 32'h4);
    ovfModel = 1'b0;
    checkStatus("status_ovf_cleared");

    // Drain to three entries, then push+pop together
    for (int i = 0; i < 5; i++) readKey("drain_to_three");
    checkStatus("status_count3");
    pushAndRead(8'h77, "pushpop_head");
    checkStatus("status_pushpop_count3");
    for (int i = 0; i < 3; i++) readKey("drain_after_pushpop");
    checkStatus("status_empty_again");

    // Push+pop on an empty FIFO: push only
    pushAndRead(8'h5A, "pushpop_empty");
    checkStatus("status_pushpop_empty");
    readKey("key_5a");

    // Fill, then drop a code while clearing overflow: set wins
    for (int i = 0; i < 8; i++) pushKey(8'(8'h60 + i));
    kbd_code     = 8'hEE;
    kbd_valid    = 1'b1;
    bus.en       = 1'b1;
    bus.addr     = addrOf(32'h4);
    bus.memWrite = 1'b1;
    bus.wdata    = 32'h4;
    modelPush(8'hEE, sbQ.size() == int'(FIFO_DEPTH));
    @(posedge clk);
    #1;
    kbd_valid = 1'b0;
    busIdle();
    checkStatus("status_set_beats_clear");
    wrReg(32'h4, 32'h4);
    ovfModel = 1'b0;
    for (int i = 0; i < 8; i++) readKey("drain_full");
    checkStatus("status_final_empty");

    // Millisecond counter (terminal count 3)
    wrReg(32'h8, 32'h0);
    repeat (40) @(posedge clk);
    #1;
    rdReg(32'h8, d);
    check("ms_after_40", d, 32'd10);
    wrReg(32'h8, 32'hFFFF_FFFF);
    repeat (3) @(posedge clk);
    #1;
    rdReg(32'h8, d);
    check("ms_before_wrap", d, 32'hFFFF_FFFF);
    rdReg(32'h8, d);
    check("ms_wrapped", d, 32'h0);
    wrReg(32'h8, 32'h0);
    repeat (3) @(posedge clk);
    #1;
    wrReg(32'h8, 32'h100);
    repeat (3) @(posedge clk);
    #1;
    rdReg(32'h8, d);
    check("ms_write_in_terminal", d, 32'h100);
    rdReg(32'h8, d);
    check("ms_next_increment", d, 32'h101);

    // LED register
    bus.en       = 1'b1;
    bus.addr     = addrOf(32'hC);
    bus.memWrite = 1'b1;
    bus.wdata    = 32'h0000_A5A5;
    #1;
    check("leds_before_edge", 32'(leds), 32'h0);
    @(posedge clk);
    #1;
    busIdle();
    check("leds_after_edge", 32'(leds), 32'h0000_A5A5);
    wrReg(32'hC, 32'h8000_FFFF);
    rdReg(32'hC, d);
`ifdef IO_PORT_IRQ_EN
    check("leds_readback", d, 32'h8000_FFFF);
`else
    check("leds_readback", d, 32'h0000_FFFF);
`endif

    // Out-of-window address reads zero
    bus.en      = 1'b1;
    bus.addr    = 13'h0014;
    bus.memRead = 1'b1;
    #1;
    check("out_of_window", bus.rdata, 32'h0);
    @(posedge clk);
    #1;
    busIdle();

    // Button synchronizer latency
    btn = 4'b1010;
    @(posedge clk);
    #1;
    checkStatus("btn_one_cycle");
    btnModel = 4'hA;
    checkStatus("btn_two_cycles");

    // Asynchronous mid-cycle reset
    pushKey(8'h11);
    pushKey(8'h22);
    #2 rst = 1'b0;
    #1;
    sbQ.delete();
    ovfModel = 1'b0;
    btnModel = '0;
    check("rst_leds", 32'(leds), 32'h0);
    bus.en      = 1'b1;
    bus.addr    = addrOf(32'h4);
    bus.memRead = 1'b1;
    #1;
    check("rst_status", bus.rdata, expStatus());
    bus.addr = addrOf(32'h8);
    #1;
    check("rst_mscount", bus.rdata, 32'h0);
    busIdle();
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    readKey("rst_keydata_empty");

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
